fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. Holds the program counter, drives the byte address to the combinational instruction memory, and registers the returned word plus PC+4 into the IF/ID pipeline register. Sits directly upstream of instruction decode. Responds to freeze requests from the hazard unit and to taken-branch redirects from the branch-resolve logic.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_pc_register.sv | 30 +++
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage: datapath width,
// NOP encoding, default reset PC and the IF/ID register layout.
package fetch_stage_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [XLEN-1:0] NOP          = '0;
    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instruction;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc_plus4: '0, instruction: NOP, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program-counter register: synchronous reset to RESET_PC, loads d only
// when enabled.
module fetch_stage_pc_register
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     n        = XLEN,
    parameter logic [n-1:0]    RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en_i,
    input  logic [n-1:0] pc_d_i,
    output logic [n-1:0] pc_q_o
);

    logic [n-1:0] pc_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_en_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC drives the combinational instruction memory, and the
// returned word plus PC+4 is registered into IF/ID. Redirects beat freezes.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     n        = XLEN,
    parameter logic [n-1:0]    RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         br_taken,
    input  logic [n-1:0] br_target,
    output logic [n-1:0] imem_pc,
    input  logic [n-1:0] imem_instruction,
    output logic [n-1:0] if_pc_plus4,
    output logic [n-1:0] if_instruction,
    output logic         if_valid
);

    logic [n-1:0] pc_q;
    logic [n-1:0] pc_d;
    logic [n-1:0] pc_plus4;
    logic         pc_load_en;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    // Wraps modulo 2^n with no overflow indication.
    assign pc_plus4   = pc_q + n'(4);
    assign pc_d       = br_taken ? br_target : pc_plus4;
    assign pc_load_en = ~freeze | br_taken;

    fetch_stage_pc_register #(
        .n        (n),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .rst       (rst),
        .load_en_i (pc_load_en),
        .pc_d_i    (pc_d),
        .pc_q_o    (pc_q)
    );

    // NOTE: if_id_d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        if_id_d = if_id_q;
        if (br_taken) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (!freeze) begin
            if_id_d.pc_plus4    = pc_plus4;
            if_id_d.instruction = imem_instruction;
            if_id_d.valid       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign imem_pc        = pc_q;
    assign if_pc_plus4    = if_id_q.pc_plus4;
    assign if_instruction = if_id_q.instruction;
    assign if_valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized reset/freeze/redirect traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        if_valid;

    logic [31:0] mem [64];

    // Reference model of the architectural state.
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_pc[7:2]];

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .if_pc_plus4      (if_pc_plus4),
        .if_instruction   (if_instruction),
        .if_valid         (if_valid)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the stage's rules,
    // clock the DUT and compare every output just after the edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] tgt);
        logic [5:0] idx;
        rst       = r;
        freeze    = f;
        br_taken  = b;
        br_target = tgt;
        idx       = m_pc[7:2];
        if (r) begin
            m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (b) begin
            m_pc = tgt; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!f) begin
            m_instr = mem[idx];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("imem_pc",        imem_pc,        m_pc);
        check("if_pc_plus4",    if_pc_plus4,    m_pc4);
        check("if_instruction", if_instruction, m_instr);
        check("if_valid",       {31'b0, if_valid}, {31'b0, m_valid});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i;
        m_pc = 32'hx; m_pc4 = 32'hx; m_instr = 32'hx; m_valid = 1'bx;
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        @(negedge clk);

        // Reset, with stray branch/freeze ignored, then free-run.
        step(1, 1, 1, 32'h40);
        step(1, 0, 0, 32'h0);
        check("reset_pc", imem_pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 32'h0);
            check("run_pc4",   if_pc_plus4,    32'(4 * i));
            check("run_instr", if_instruction, 32'(i - 1));
        end

        // Freeze for three cycles at PC=8.
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        check("pre_freeze_pc", imem_pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0);
            check("freeze_pc",  imem_pc,     32'h8);
            check("freeze_pc4", if_pc_plus4, 32'h8);
        end
        step(0, 0, 0, 32'h0);
        check("resume_pc4", if_pc_plus4, 32'hC);
        check("resume_ins", if_instruction, 32'h2);
        step(0, 0, 0, 32'h0);
        check("resume_pc4b", if_pc_plus4, 32'h10);

        // Redirect from PC=0xB0 to 0x74.
        step(0, 0, 1, 32'hB0);
        step(0, 0, 1, 32'h74);
        check("br_pc",    imem_pc, 32'h74);
        check("br_valid", {31'b0, if_valid}, 32'h0);
        step(0, 0, 0, 32'h0);
        check("br_tgt_pc4",   if_pc_plus4, 32'h78);
        check("br_tgt_valid", {31'b0, if_valid}, 32'h1);
        check("br_tgt_instr", if_instruction, 32'h1D);

        // Redirect wins over freeze.
        step(0, 1, 1, 32'h20);
        check("brfrz_pc", imem_pc, 32'h20);
        check("brfrz_valid", {31'b0, if_valid}, 32'h0);

        // Reset mid-run beats a branch.
        step(0, 0, 0, 32'h0);
        step(1, 0, 1, 32'h40);
        check("rstbr_pc", imem_pc, 32'h0);

        // Unaligned target: low bits carried, ignored for indexing.
        step(0, 0, 1, 32'h13);
        step(0, 0, 0, 32'h0);
        check("unal_pc",    imem_pc,        32'h17);
        check("unal_instr", if_instruction, 32'h4);

        // PC wrap at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        check("wrap_pc",  imem_pc,     32'h0);
        check("wrap_pc4", if_pc_plus4, 32'h0);

        // Randomized traffic with random memory contents.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic        r, f, b;
            logic [31:0] t;
            r = ($urandom_range(31) == 0);
            f = ($urandom_range(3) == 0);
            b = ($urandom_range(7) == 0);
            t = ($urandom_range(1) == 0) ? $urandom : {24'h0, 8'($urandom)};
            step(r, f, b, t);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
